dram_line_buffer: RTL and testbench

DRAM_LINE_BUFFER -- requirements
Module: dram_line_buffer

---
 rtl/dram_line_buffer_pkg.sv | 40 ++++
 rtl/dram_line_buffer.sv | 142 ++++++++++++++
 tb/tb_dram_line_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_line_buffer_pkg.sv
// Shared widths, state encoding and line/word helpers for the single-line DRAM buffer.
// The buffer holds one 128-bit line in front of a DRAM controller.
package dram_line_buffer_pkg;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int LINE_W = 128;
    localparam int STRB_W = WORD_W / 8;
    localparam int WORDS  = LINE_W / WORD_W;
    localparam int TAG_W  = ADDR_W - 4;

    typedef enum logic [2:0] {
        ST_CALIB = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    function automatic logic [WORD_W-1:0] select_word(input logic [LINE_W-1:0] line,
                                                      input logic [1:0] sel);
        return line[sel*WORD_W +: WORD_W];
    endfunction

    // Only the word addressed by sel changes, and only the byte lanes enabled in strb.
    function automatic logic [LINE_W-1:0] merge_line(input logic [LINE_W-1:0] line,
                                                     input logic [1:0] sel,
                                                     input logic [WORD_W-1:0] wdata,
                                                     input logic [STRB_W-1:0] strb);
        logic [LINE_W-1:0] res;
        res = line;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[sel*WORD_W + b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dram_line_buffer.sv
// Single-line read buffer with write-through in front of a DRAM controller.
// Read hits are served locally; misses and all writes go to DRAM.
module dram_line_buffer
    import dram_line_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_x_async,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [WORD_W-1:0] i_req_wdata,
    input  logic [STRB_W-1:0] i_req_wstrb,
    input  logic              i_flush,
    output logic              o_rsp_valid,
    output logic [WORD_W-1:0] o_rsp_rdata,
    output logic              o_calib_done,
    output logic              o_d_rd_en,
    output logic              o_d_wr_en,
    output logic [ADDR_W-1:0] o_d_addr,
    output logic [WORD_W-1:0] o_d_data,
    output logic [STRB_W-1:0] o_d_mask,
    input  logic              i_d_busy,
    input  logic              i_d_init_calib_complete,
    input  logic [LINE_W-1:0] i_d_data
);

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic                first_q, first_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [WORD_W-1:0]   rsp_q, rsp_d;
    logic                req_hit;

    assign req_hit = valid_q && (tag_q == i_req_addr[ADDR_W-1:4]);

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        first_d      = 1'b0;
        tag_d        = tag_q;
        line_d       = line_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rsp_d        = rsp_q;
        o_req_ready  = 1'b0;
        o_rsp_valid  = 1'b0;
        o_rsp_rdata  = '0;
        o_calib_done = (state_q != ST_CALIB);
        o_d_rd_en    = 1'b0;
        o_d_wr_en    = 1'b0;
        o_d_addr     = '0;
        o_d_data     = '0;
        o_d_mask     = '0;

        case (state_q)
            ST_CALIB: begin
                if (i_d_init_calib_complete) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (!i_req_we && req_hit) begin
                        rsp_d   = select_word(line_q, i_req_addr[3:2]);
                        state_d = ST_RESP;
                    end else begin
                        addr_d  = i_req_addr;
                        we_d    = i_req_we;
                        wdata_d = i_req_wdata;
                        wstrb_d = i_req_wstrb;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                o_d_rd_en = !we_q;
                o_d_wr_en = we_q;
                o_d_addr  = addr_q;
                o_d_data  = we_q ? wdata_q : '0;
                o_d_mask  = we_q ? ~wstrb_q : '0;
                first_d   = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // Busy may lag the command by a cycle, so the first WAIT cycle never exits.
                if (!first_q && !i_d_busy) begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        line_d  = i_d_data;
                        tag_d   = addr_q[ADDR_W-1:4];
                        valid_d = 1'b1;
                        rsp_d   = select_word(i_d_data, addr_q[3:2]);
                    end else begin
                        rsp_d = '0;
                        if (valid_q && (tag_q == addr_q[ADDR_W-1:4])) begin
                            line_d = merge_line(line_q, addr_q[3:2], wdata_q, wstrb_q);
                        end
                    end
                end
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_rdata = rsp_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_CALIB;
        endcase

        // Flush overrides a line capture in the same cycle; the captured word is still returned.
        if (i_flush) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_x_async) begin
        if (!rst_x_async) begin
            state_q <= ST_CALIB;
            valid_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            first_q <= first_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q   <= tag_d;
        line_q  <= line_d;
        addr_q  <= addr_d;
        we_q    <= we_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
        rsp_q   <= rsp_d;
    end

endmodule

// File: tb/tb_dram_line_buffer.sv
// Directed bench for dram_line_buffer: calibration gating, hit/miss reads, write-through,
// flush behaviour and reset during an outstanding DRAM access.
module tb_dram_line_buffer;

    logic         clk = 1'b0;
    logic         rst_x_async;
    logic         i_req_valid;
    logic         o_req_ready;
    logic         i_req_we;
    logic [31:0]  i_req_addr;
    logic [31:0]  i_req_wdata;
    logic [3:0]   i_req_wstrb;
    logic         i_flush;
    logic         o_rsp_valid;
    logic [31:0]  o_rsp_rdata;
    logic         o_calib_done;
    logic         o_d_rd_en;
    logic         o_d_wr_en;
    logic [31:0]  o_d_addr;
    logic [31:0]  o_d_data;
    logic [3:0]   o_d_mask;
    logic         i_d_busy;
    logic         i_d_init_calib_complete;
    logic [127:0] i_d_data;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int rsp_cnt = 0;
    logic [31:0] last_d_addr = '0;
    logic [31:0] last_d_data = '0;
    logic [3:0]  last_d_mask = '0;

    localparam logic [127:0] LINE_A = {32'h44443333, 32'h22221111, 32'h66665555, 32'h88887777};
    localparam logic [127:0] LINE_B = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

    always #5 clk = ~clk;

    dram_line_buffer dut (
        .clk                     (clk),
        .rst_x_async             (rst_x_async),
        .i_req_valid             (i_req_valid),
        .o_req_ready             (o_req_ready),
        .i_req_we                (i_req_we),
        .i_req_addr              (i_req_addr),
        .i_req_wdata             (i_req_wdata),
        .i_req_wstrb             (i_req_wstrb),
        .i_flush                 (i_flush),
        .o_rsp_valid             (o_rsp_valid),
        .o_rsp_rdata             (o_rsp_rdata),
        .o_calib_done            (o_calib_done),
        .o_d_rd_en               (o_d_rd_en),
        .o_d_wr_en               (o_d_wr_en),
        .o_d_addr                (o_d_addr),
        .o_d_data                (o_d_data),
        .o_d_mask                (o_d_mask),
        .i_d_busy                (i_d_busy),
        .i_d_init_calib_complete (i_d_init_calib_complete),
        .i_d_data                (i_d_data)
    );

    always @(negedge clk) begin
        if (o_d_rd_en) begin
            rd_cnt      <= rd_cnt + 1;
            last_d_addr <= o_d_addr;
            last_d_data <= o_d_data;
            last_d_mask <= o_d_mask;
        end
        if (o_d_wr_en) begin
            wr_cnt      <= wr_cnt + 1;
            last_d_addr <= o_d_addr;
            last_d_data <= o_d_data;
            last_d_mask <= o_d_mask;
        end
        if (o_rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    // One request; returns response latency in cycles after drive and the response word.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int busy_cycles, input int flush_at,
                          output int lat, output logic [31:0] rdata, output logic got);
        @(negedge clk); #1;
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        i_req_wstrb = wstrb;
        i_d_busy    = (busy_cycles > 0);
        got = 1'b0;
        lat = 0;
        rdata = '0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk); #1;
            if (n == 1) i_req_valid = 1'b0;
            if (n == busy_cycles) i_d_busy = 1'b0;
            i_flush = (n == flush_at);
            if (o_rsp_valid) begin
                got   = 1'b1;
                lat   = n;
                rdata = o_rsp_rdata;
            end
        end
        i_flush  = 1'b0;
        i_d_busy = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rsp_timeout addr=%h: no response within 40 cycles, required one", addr);
        end
    endtask

    task automatic test_reset;
        rst_x_async = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({o_req_ready, o_rsp_valid, o_calib_done, o_d_rd_en, o_d_wr_en} !== 5'b0 ||
            o_rsp_rdata !== 32'h0 || o_d_addr !== 32'h0 || o_d_data !== 32'h0 || o_d_mask !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rsp=%b calib=%b rd=%b wr=%b rdata=%h daddr=%h ddata=%h mask=%h, required all 0",
                     o_req_ready, o_rsp_valid, o_calib_done, o_d_rd_en, o_d_wr_en,
                     o_rsp_rdata, o_d_addr, o_d_data, o_d_mask);
        end
    endtask

    task automatic test_calib;
        logic bad;
        bad = 1'b0;
        rst_x_async = 1'b1;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0000_1000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (o_req_ready || o_d_rd_en || o_d_wr_en || o_calib_done || o_rsp_valid) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL calib_gate: ready/strobe/calib_done seen while uncalibrated, required none");
        end
        i_req_valid = 1'b0;
        i_d_init_calib_complete = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (o_req_ready !== 1'b1 || o_calib_done !== 1'b1) begin
            errors++;
            $display("FAIL calib_ready: ready=%b calib_done=%b, required 1 1", o_req_ready, o_calib_done);
        end
        i_d_init_calib_complete = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (o_req_ready !== 1'b1 || o_calib_done !== 1'b1) begin
            errors++;
            $display("FAIL calib_drop_ignored: ready=%b calib_done=%b, required 1 1", o_req_ready, o_calib_done);
        end
    endtask

    task automatic test_read_miss_hit;
        int lat, rd0;
        logic [31:0] rdata;
        logic got;
        i_d_data = LINE_A;
        rd0 = rd_cnt;
        do_req(1'b0, 32'h0000_1000, 32'h0, 4'h0, 5, 0, lat, rdata, got);
        checks++;
        if (rd_cnt - rd0 !== 1 || rdata !== 32'h88887777 || lat !== 6) begin
            errors++;
            $display("FAIL read_miss: rd_en=%0d rdata=%h lat=%0d, required 1 88887777 6", rd_cnt - rd0, rdata, lat);
        end
        checks++;
        if (last_d_addr !== 32'h0000_1000 || last_d_data !== 32'h0 || last_d_mask !== 4'h0) begin
            errors++;
            $display("FAIL read_cmd: addr=%h data=%h mask=%h, required 00001000 00000000 0",
                     last_d_addr, last_d_data, last_d_mask);
        end
        rd0 = rd_cnt;
        do_req(1'b0, 32'h0000_1008, 32'h0, 4'h0, 0, 0, lat, rdata, got);
        checks++;
        if (rd_cnt - rd0 !== 0 || rdata !== 32'h22221111 || lat !== 1) begin
            errors++;
            $display("FAIL read_hit: rd_en=%0d rdata=%h lat=%0d, required 0 22221111 1", rd_cnt - rd0, rdata, lat);
        end
    endtask

    task automatic test_write_through;
        int lat, rd0, wr0;
        logic [31:0] rdata;
        logic got;
        wr0 = wr_cnt;
        do_req(1'b1, 32'h0000_1004, 32'hAABBCCDD, 4'b0011, 0, 0, lat, rdata, got);
        checks++;
        if (wr_cnt - wr0 !== 1 || last_d_mask !== 4'b1100 || last_d_data !== 32'hAABBCCDD ||
            last_d_addr !== 32'h0000_1004 || rdata !== 32'h0 || lat !== 4) begin
            errors++;
            $display("FAIL write_cmd: wr=%0d mask=%b data=%h addr=%h rdata=%h lat=%0d, required 1 1100 aabbccdd 00001004 0 4",
                     wr_cnt - wr0, last_d_mask, last_d_data, last_d_addr, rdata, lat);
        end
        rd0 = rd_cnt;
        do_req(1'b0, 32'h0000_1004, 32'h0, 4'h0, 0, 0, lat, rdata, got);
        checks++;
        if (rd_cnt - rd0 !== 0 || rdata !== 32'h6666CCDD) begin
            errors++;
            $display("FAIL write_merge: rd_en=%0d rdata=%h, required 0 6666ccdd", rd_cnt - rd0, rdata);
        end
        wr0 = wr_cnt;
        do_req(1'b1, 32'h0000_2000, 32'h12345678, 4'h0, 0, 0, lat, rdata, got);
        checks++;
        if (wr_cnt - wr0 !== 1 || last_d_mask !== 4'hF || !got) begin
            errors++;
            $display("FAIL write_nostrb: wr=%0d mask=%h got=%b, required 1 f 1", wr_cnt - wr0, last_d_mask, got);
        end
        rd0 = rd_cnt;
        do_req(1'b0, 32'h0000_100C, 32'h0, 4'h0, 0, 0, lat, rdata, got);
        checks++;
        if (rd_cnt - rd0 !== 0 || rdata !== 32'h44443333) begin
            errors++;
            $display("FAIL write_miss_unchanged: rd_en=%0d rdata=%h, required 0 44443333", rd_cnt - rd0, rdata);
        end
        i_d_data = LINE_B;
        rd0 = rd_cnt;
        do_req(1'b0, 32'h0000_2000, 32'h0, 4'h0, 0, 0, lat, rdata, got);
        checks++;
        if (rd_cnt - rd0 !== 1 || rdata !== 32'hAAAA0000) begin
            errors++;
            $display("FAIL no_write_allocate: rd_en=%0d rdata=%h, required 1 aaaa0000", rd_cnt - rd0, rdata);
        end
    endtask

    task automatic test_flush;
        int lat, rd0;
        logic [31:0] rdata;
        logic got;
        @(negedge clk); #1;
        i_flush = 1'b1;
        @(negedge clk); #1;
        i_flush = 1'b0;
        rd0 = rd_cnt;
        do_req(1'b0, 32'h0000_2000, 32'h0, 4'h0, 0, 0, lat, rdata, got);
        checks++;
        if (rd_cnt - rd0 !== 1 || rdata !== 32'hAAAA0000) begin
            errors++;
            $display("FAIL flush_reissue: rd_en=%0d rdata=%h, required 1 aaaa0000", rd_cnt - rd0, rdata);
        end
        rd0 = rd_cnt;
        do_req(1'b0, 32'h0000_3004, 32'h0, 4'h0, 0, 3, lat, rdata, got);
        checks++;
        if (rd_cnt - rd0 !== 1 || rdata !== 32'hBBBB0001 || lat !== 4) begin
            errors++;
            $display("FAIL flush_capture_rsp: rd_en=%0d rdata=%h lat=%0d, required 1 bbbb0001 4", rd_cnt - rd0, rdata, lat);
        end
        rd0 = rd_cnt;
        do_req(1'b0, 32'h0000_3004, 32'h0, 4'h0, 0, 0, lat, rdata, got);
        checks++;
        if (rd_cnt - rd0 !== 1) begin
            errors++;
            $display("FAIL flush_wins: rd_en=%0d, required 1", rd_cnt - rd0);
        end
    endtask

    task automatic test_reset_in_wait;
        int rsp0;
        logic bad;
        @(negedge clk); #1;
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_addr  = 32'h0000_5000;
        i_d_busy    = 1'b1;
        @(negedge clk); #1;
        i_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rsp0 = rsp_cnt;
        rst_x_async = 1'b0;
        #1;
        checks++;
        if ({o_req_ready, o_rsp_valid, o_calib_done, o_d_rd_en, o_d_wr_en} !== 5'b0 ||
            o_rsp_rdata !== 32'h0 || o_d_addr !== 32'h0 || o_d_data !== 32'h0 || o_d_mask !== 4'h0) begin
            errors++;
            $display("FAIL wait_reset_outputs: ready=%b rsp=%b calib=%b rd=%b wr=%b, required all 0",
                     o_req_ready, o_rsp_valid, o_calib_done, o_d_rd_en, o_d_wr_en);
        end
        repeat (2) @(negedge clk);
        #1;
        rst_x_async = 1'b1;
        i_d_busy    = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (o_calib_done || o_req_ready) bad = 1'b1;
        end
        checks++;
        if (rsp_cnt !== rsp0 || bad) begin
            errors++;
            $display("FAIL wait_reset_abort: rsp=%0d not_calib_state=%b, required 0 0", rsp_cnt - rsp0, bad);
        end
        i_d_init_calib_complete = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_reset_recal: ready=%b, required 1", o_req_ready);
        end
    endtask

    initial begin
        rst_x_async = 1'b0;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        i_req_wstrb = '0;
        i_flush     = 1'b0;
        i_d_busy    = 1'b0;
        i_d_init_calib_complete = 1'b0;
        i_d_data    = '0;
        test_reset;
        test_calib;
        test_read_miss_hit;
        test_write_through;
        test_flush;
        test_reset_in_wait;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
